// File: rtl/rd_desc_sched.sv
// Descriptor scheduler for the packet read controller: queues begin/end/control
// descriptors and launches them one at a time with back-pressure and a completion timeout.
module rd_desc_sched #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_LEN        = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic [31:0]              desc_begin,
    input  logic [31:0]              desc_end,
    input  logic [31:0]              desc_control,
    input  logic                     enable,
    input  logic                     fifo_almost_full,
    output logic                     rd_start,
    output logic [31:0]              pkt_begin,
    output logic [31:0]              pkt_end,
    output logic [31:0]              control,
    input  logic                     rd_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [31:0]              dispatched_count,
    output logic                     err_bad_desc,
    output logic                     err_timeout,
    input  logic                     clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COOLDOWN} state_t;

    state_t          state_reg;
    logic [95:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [TW-1:0]   timer_reg;
    logic            rd_start_reg;
    logic            busy_reg;
    logic [31:0]     pkt_begin_reg;
    logic [31:0]     pkt_end_reg;
    logic [31:0]     control_reg;
    logic [31:0]     dispatched_reg;
    logic            err_bad_reg;
    logic            err_timeout_reg;

    logic [31:0]     desc_len;
    logic            desc_legal;
    logic            push_ok;
    logic            push_bad;
    logic            launch_go;
    logic            timeout_hit;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign desc_ready  = (count_reg != CW'(DEPTH));
    assign desc_len    = desc_end - desc_begin;
    assign desc_legal  = (desc_end > desc_begin) && (desc_len <= 32'(MAX_LEN));
    assign push_ok     = desc_valid && desc_ready && desc_legal;
    assign push_bad    = desc_valid && desc_ready && !desc_legal;
    assign launch_go   = (state_reg == IDLE) && enable && (count_reg != '0) && !fifo_almost_full;
    assign timeout_hit = (state_reg == WAIT) && !rd_done && (timer_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= {desc_control, desc_end, desc_begin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (launch_go)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push_ok) - CW'(launch_go);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_bad_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_bad_reg     <= push_bad    | (err_bad_reg     & ~clr_err);
            err_timeout_reg <= timeout_hit | (err_timeout_reg & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            rd_start_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            pkt_begin_reg  <= '0;
            pkt_end_reg    <= '0;
            control_reg    <= '0;
            dispatched_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch_go) begin
                        {control_reg, pkt_end_reg, pkt_begin_reg} <= mem[rd_ptr_reg];
                        rd_start_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    rd_start_reg <= 1'b0;
                    timer_reg    <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (rd_done) begin
                        dispatched_reg <= dispatched_reg + 32'd1;
                        state_reg      <= COOLDOWN;
                    end else if (timeout_hit) begin
                        state_reg <= COOLDOWN;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                COOLDOWN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_start         = rd_start_reg;
    assign busy             = busy_reg;
    assign pkt_begin        = pkt_begin_reg;
    assign pkt_end          = pkt_end_reg;
    assign control          = control_reg;
    assign queue_count      = count_reg;
    assign dispatched_count = dispatched_reg;
    assign err_bad_desc     = err_bad_reg;
    assign err_timeout      = err_timeout_reg;
endmodule

// File: tb/tb_rd_desc_sched.sv
// Directed bench for rd_desc_sched: a long-timeout instance for the main flows and a
// 16-cycle-timeout instance sharing the same inputs for the timeout scenario.
module tb_rd_desc_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        desc_valid = 1'b0;
    logic [31:0] desc_begin = '0;
    logic [31:0] desc_end = '0;
    logic [31:0] desc_control = '0;
    logic        enable = 1'b0;
    logic        fifo_almost_full = 1'b0;
    logic        clr_err = 1'b0;
    logic        auto_done = 1'b0;
    logic        man_done = 1'b0;
    logic        rd_done;

    logic        desc_ready, rd_start, busy, err_bad_desc, err_timeout;
    logic [31:0] pkt_begin, pkt_end, control, dispatched_count;
    logic [3:0]  queue_count;

    logic        t_desc_ready, t_rd_start, t_busy, t_err_bad_desc, t_err_timeout;
    logic [31:0] t_pkt_begin, t_pkt_end, t_control, t_dispatched_count;
    logic [3:0]  t_queue_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int resp_k   = 0;
    int cd       = 0;
    int          start_cyc[$];
    logic [31:0] start_beg[$];

    assign rd_done = auto_done | man_done;

    always #5 clk = ~clk;

    rd_desc_sched #(.DEPTH(8), .TIMEOUT_CYCLES(65535), .MAX_LEN(65535)) dut (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_begin(desc_begin), .desc_end(desc_end), .desc_control(desc_control),
        .enable(enable), .fifo_almost_full(fifo_almost_full), .rd_start(rd_start),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end), .control(control), .rd_done(rd_done),
        .busy(busy), .queue_count(queue_count), .dispatched_count(dispatched_count),
        .err_bad_desc(err_bad_desc), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    rd_desc_sched #(.DEPTH(8), .TIMEOUT_CYCLES(16), .MAX_LEN(65535)) dut_t (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(t_desc_ready),
        .desc_begin(desc_begin), .desc_end(desc_end), .desc_control(desc_control),
        .enable(enable), .fifo_almost_full(fifo_almost_full), .rd_start(t_rd_start),
        .pkt_begin(t_pkt_begin), .pkt_end(t_pkt_end), .control(t_control), .rd_done(rd_done),
        .busy(t_busy), .queue_count(t_queue_count), .dispatched_count(t_dispatched_count),
        .err_bad_desc(t_err_bad_desc), .err_timeout(t_err_timeout), .clr_err(clr_err)
    );

    always @(posedge clk) cyc++;

    // Reader model: one-cycle done pulse resp_k cycles after each rd_start (0 = never).
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) auto_done = 1'b1;
        end
        if (rd_start && resp_k > 0) cd = resp_k;
        if (rd_start) begin
            start_cyc.push_back(cyc);
            start_beg.push_back(pkt_begin);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cd = 0;
        start_cyc.delete();
        start_beg.delete();
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] e, input logic [31:0] c);
        desc_valid   = 1'b1;
        desc_begin   = b;
        desc_end     = e;
        desc_control = c;
        tick();
        desc_valid   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int limit);
        for (int i = 0; i < limit && !rd_start; i++) tick();
        check(tag, rd_start, 1'b1);
    endtask

    task automatic wait_dispatched(input string tag, input logic [31:0] n, input int limit);
        for (int i = 0; i < limit && dispatched_count != n; i++) tick();
        check(tag, dispatched_count, n);
    endtask

    initial begin
        // Reset state
        tick();
        do_reset();
        check("rst_rd_start", rd_start, 0);
        check("rst_pkt_begin", pkt_begin, 0);
        check("rst_busy", busy, 0);
        check("rst_queue_count", queue_count, 0);
        check("rst_dispatched", dispatched_count, 0);
        check("rst_errs", {err_bad_desc, err_timeout}, 0);
        check("rst_desc_ready", desc_ready, 1);

        // 1: single descriptor, done 20 cycles after start
        resp_k = 20;
        enable = 1'b1;
        push(32'h1000, 32'h1010, 32'hA5);
        wait_start("t1_start", 10);
        check("t1_pkt_begin", pkt_begin, 32'h1000);
        check("t1_pkt_end", pkt_end, 32'h1010);
        check("t1_control", control, 32'hA5);
        repeat (20) tick();
        check("t1_busy_at_done", busy, 1);
        tick();
        check("t1_busy_cooldown", busy, 1);
        check("t1_dispatched", dispatched_count, 1);
        tick();
        check("t1_busy_fall", busy, 0);
        repeat (10) tick();
        check("t1_one_start", start_beg.size(), 1);
        check("t1_pkt_hold", pkt_begin, 32'h1000);

        // 2: fill queue while disabled, then drain with immediate done
        do_reset();
        enable = 1'b0;
        resp_k = 1;
        for (int i = 0; i < 8; i++)
            push(32'h2000 + 32'(i) * 32'h100, 32'h2040 + 32'(i) * 32'h100, 32'(i));
        check("t2_count_full", queue_count, 8);
        check("t2_ready_full", desc_ready, 0);
        push(32'h9000, 32'h9040, 32'h99);
        check("t2_ninth_rejected", queue_count, 8);
        enable = 1'b1;
        wait_dispatched("t2_dispatched", 8, 200);
        check("t2_starts", start_beg.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_order_%0d", i), start_beg[i], 32'h2000 + 32'(i) * 32'h100);
        for (int i = 1; i < 8; i++)
            check($sformatf("t2_spacing_%0d", i), start_cyc[i] - start_cyc[i-1], 4);
        check("t2_empty", queue_count, 0);

        // 3: malformed descriptors
        do_reset();
        enable = 1'b1;
        push(32'h3000, 32'h3000, 32'h1);
        check("t3_eq_err", err_bad_desc, 1);
        check("t3_eq_count", queue_count, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("t3_clr", err_bad_desc, 0);
        push(32'h3010, 32'h3000, 32'h2);
        check("t3_lt_err", err_bad_desc, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        clr_err = 1'b1;
        push(32'h4000, 32'h4000 + 32'd65536, 32'h3);
        clr_err = 1'b0;
        check("t3_long_set_wins", err_bad_desc, 1);
        repeat (5) tick();
        check("t3_no_start", start_beg.size(), 0);
        check("t3_count_zero", queue_count, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("t3_clr2", err_bad_desc, 0);
        resp_k = 1;
        push(32'h5000, 32'h5000 + 32'd65535, 32'h4);
        check("t3_maxlen_ok", err_bad_desc, 0);
        wait_start("t3_maxlen_start", 10);

        // 4: back-pressure
        do_reset();
        enable = 1'b1;
        fifo_almost_full = 1'b1;
        resp_k = 5;
        push(32'hA000, 32'hA010, 32'h10);
        push(32'hB000, 32'hB010, 32'h11);
        repeat (10) tick();
        check("t4_held_no_start", start_beg.size(), 0);
        check("t4_held_count", queue_count, 2);
        fifo_almost_full = 1'b0;
        tick();
        check("t4_release_start", rd_start, 1);
        fifo_almost_full = 1'b1;
        wait_dispatched("t4_first_done", 1, 50);
        repeat (10) tick();
        check("t4_second_held", start_beg.size(), 1);
        check("t4_second_queued", queue_count, 1);
        fifo_almost_full = 1'b0;
        tick();
        check("t4_second_start", rd_start, 1);
        check("t4_second_begin", pkt_begin, 32'hB000);
        wait_dispatched("t4_second_done", 2, 50);

        // 5: timeout on the 16-cycle instance
        do_reset();
        enable = 1'b1;
        resp_k = 0;
        push(32'h6000, 32'h6010, 32'h20);
        push(32'h7000, 32'h7010, 32'h21);
        for (int i = 0; i < 10 && !t_rd_start; i++) tick();
        check("t5_start", t_rd_start, 1);
        tick();
        repeat (15) tick();
        check("t5_no_err_yet", t_err_timeout, 0);
        tick();
        check("t5_err_timeout", t_err_timeout, 1);
        check("t5_dispatched", t_dispatched_count, 0);
        man_done = 1'b1; tick(); man_done = 1'b0;
        check("t5_late_done_ignored", t_dispatched_count, 0);
        tick();
        check("t5_next_start", t_rd_start, 1);
        check("t5_next_begin", t_pkt_begin, 32'h7000);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("t5_clr_timeout", t_err_timeout, 0);

        // 6: reset during WAIT
        do_reset();
        enable = 1'b1;
        resp_k = 0;
        for (int i = 0; i < 4; i++)
            push(32'hC000 + 32'(i) * 32'h100, 32'hC010 + 32'(i) * 32'h100, 32'(i));
        check("t6_busy", busy, 1);
        check("t6_queued", queue_count, 3);
        reset = 1'b1;
        tick();
        check("t6_rst_count", queue_count, 0);
        check("t6_rst_outs", {rd_start, busy, err_bad_desc, err_timeout}, 0);
        check("t6_rst_pkt", {pkt_begin, pkt_end}, 0);
        check("t6_rst_ctrl", control, 0);
        check("t6_rst_ready", desc_ready, 1);
        reset = 1'b0;
        repeat (10) tick();
        check("t6_no_start", start_beg.size(), 1);
        push(32'hD000, 32'hD010, 32'h30);
        wait_start("t6_new_start", 10);
        check("t6_new_begin", pkt_begin, 32'hD000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rd_desc_sched.md
Name: rd_desc_sched

Overview:
Descriptor scheduler that sequences the packet read controller (the Avalon-MM burst reader that copies a packet from memory into the capture FIFO).
- The HPS-side CSR logic pushes packet descriptors (begin/end address, control word) into a small internal queue.
- The block launches them one at a time: it pulses the reader's start input, holds the descriptor stable, and waits for the reader's one-cycle done pulse.
- It enforces FIFO back-pressure, a completion timeout, and error/progress reporting.

Parameters:
DEPTH, 8, descriptor queue entries; power of two, minimum 2
TIMEOUT_CYCLES, 65535, max cycles in WAIT before abandoning a descriptor; minimum 2
MAX_LEN, 65535, largest legal (desc_end - desc_begin)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
desc_valid  in  1  descriptor push request
desc_ready  out  1  queue can accept (combinational: queue_count != DEPTH)
desc_begin  in  32  packet start address
desc_end  in  32  packet end address
desc_control  in  32  control word forwarded unchanged
enable  in  1  global dispatch enable
fifo_almost_full  in  1  capture FIFO back-pressure
rd_start  out  1  one-cycle start pulse to reader
pkt_begin  out  32  descriptor begin to reader
pkt_end  out  32  descriptor end to reader
control  out  32  descriptor control to reader
rd_done  in  1  reader completion pulse
busy  out  1  state != IDLE
queue_count  out  $clog2(DEPTH)+1  queued descriptors
dispatched_count  out  32  completed descriptors, wraps
err_bad_desc  out  1  sticky: malformed descriptor dropped
err_timeout  out  1  sticky: reader did not complete in time
clr_err  in  1  clears both sticky errors

Behaviour:
- Reset values:
  - Queue empty; state IDLE.
  - All registered outputs 0: rd_start, pkt_*, control, busy, queue_count, dispatched_count, err_*.
  - desc_ready is therefore 1.
- Push:
  - Accepted when desc_valid && desc_ready.
  - Descriptor is legal iff desc_end > desc_begin (unsigned) and (desc_end - desc_begin) <= MAX_LEN.
  - Illegal descriptor: handshake completes, nothing is enqueued, err_bad_desc is set next cycle.
- Queue:
  - Circular buffer with wrap-around read/write pointers.
  - queue_count is registered.
  - Simultaneous push and pop: count unchanged.
  - When full, desc_ready=0 even if a pop occurs in the same cycle (no pass-through).
- FSM states: IDLE, LAUNCH, WAIT, COOLDOWN.
  - IDLE -> LAUNCH when enable && queue_count>0 && !fifo_almost_full.
    - Head is popped on this edge into pkt_begin/pkt_end/control.
  - LAUNCH: rd_start=1 for exactly this cycle -> WAIT; timeout counter cleared.
  - WAIT: counter increments each cycle.
    - rd_done=1 -> COOLDOWN, dispatched_count += 1.
    - Counter reaches TIMEOUT_CYCLES-1 without rd_done -> err_timeout set -> COOLDOWN; descriptor is abandoned.
  - COOLDOWN: exactly one cycle, gives the reader time to return to idle -> IDLE.
- Timing:
  - rd_start follows the IDLE decision cycle by 1.
  - With rd_done k cycles after rd_start, the next rd_start occurs at k+3 at the earliest.
- pkt_begin/pkt_end/control hold their value from pop until the next pop.
- rd_done outside WAIT is ignored (no count, no error).
- rd_done coincident with the timeout cycle counts as done; no error.
- enable or fifo_almost_full changes are sampled only in IDLE; an in-flight descriptor always runs to done or timeout.
- clr_err clears both sticky errors; if a set condition occurs in the same cycle, set wins.
- dispatched_count wraps 0xFFFFFFFF -> 0.
- Reset mid-WAIT:
  - In-flight and queued descriptors are discarded; no rd_start is issued after reset.
  - The reader is reset by its own reset.

Test Plan:
1. Push {0x1000,0x1010,0xA5} with enable=1 and rd_done 20 cycles after rd_start -> exactly one rd_start pulse, pkt_begin=0x1000, pkt_end=0x1010, control=0xA5, dispatched_count=1, busy falls 2 cycles after rd_done.
2. Push 8 descriptors with enable=0 -> desc_ready=0 with queue_count=8; a 9th push is not accepted. Set enable=1 with immediate rd_done -> 8 launches in FIFO order, rd_start spacing = k+3 cycles.
3. Push end==begin, then end<begin, then length 65536 -> err_bad_desc=1, queue_count stays 0, no rd_start. clr_err -> err_bad_desc=0.
4. Hold fifo_almost_full=1 with 2 queued -> no rd_start. Release -> rd_start next cycle+1. Raise almost_full during WAIT -> current completes, second waits.
5. Withhold rd_done, TIMEOUT_CYCLES=16 -> err_timeout=1 sixteen cycles after entering WAIT, dispatched_count unchanged, next descriptor launches afterwards. A late rd_done is ignored.
6. Assert reset during WAIT with 3 queued -> queue_count=0 and all outputs 0 next cycle, no rd_start until a new push.
